mac_col_feeder: RTL and testbench
=================================

# mac_col_feeder

Drives one column of the systolic MAC chain from the host side and collects its result. It accepts a weight vector and shifts it into the column's weight chain, then accepts activation vectors and issues them row-by-row with a one-cycle skew. It captures the finished partial sum from the bottom MAC and returns it over a valid/ready port. It sits between the tile buffers and the MAC column: it is the transmitter for the column's W/A inputs and the receiver for its P output.

## Interface
- ROWS, 3: MACs in the column.
- A_BITWIDTH, 16: activation width, sign-magnitude (bit 15 is the sign).
- W_BITWIDTH, 8: weight width, sign-magnitude (bit 7 is the sign).
- P_BITWIDTH, 40: partial-sum width, sign-magnitude (bit 39 is the sign).
- MAC_LAT, 1: cycles from a MAC's A_en to its registered P_out.

Ports:
- clk  in  1  Single clock, rising edge.
- rst  in  1  Asynchronous, active-high reset.
- wt_valid / wt_ready  in/out  1/1  Weight vector handshake.
- wt_data  in  ROWS*W_BITWIDTH  Slice r is the weight for row r.
- act_valid / act_ready  in/out  1/1  Activation vector handshake.
- act_data  in  ROWS*A_BITWIDTH  Slice r is the activation for row r.
- res_valid / res_ready  out/in  1/1  Result handshake.
- res_data  out  P_BITWIDTH  Column sum, sign-magnitude.
- W_en  out  1  Weight shift enable into row 0.
- W_in  out  W_BITWIDTH  Weight into row 0.
- W_ready_last  in  1  W_ready of row ROWS-1.
- A_en  out  ROWS  Per-row activation enable.
- A_in  out  ROWS*A_BITWIDTH  Per-row activation.
- P_in  out  P_BITWIDTH  Partial sum into row 0; constant 0.
- P_out_last  in  P_BITWIDTH  P_out of row ROWS-1.

## Operation
- FSM states: IDLE, WLOAD, WWAIT, READY, ISSUE, DRAIN, OUT.
- IDLE: wt_ready=1. On a weight handshake, register wt_data and go to WLOAD.
- WLOAD: W_en=1 for exactly ROWS cycles. On cycle k, W_in = weight[ROWS-1-k], so the deepest row is sent first. Then go to WWAIT.
- WWAIT: W_en=0. Wait for W_ready_last=1, then go to READY. There is no timeout.
- READY: act_ready=1 and wt_ready=1.
  - On an activation handshake, register act_data and go to ISSUE.
  - On a weight handshake, go to WLOAD (reload).
  - If both are valid together, the activation wins; wt_ready is deasserted that cycle.
- ISSUE: ROWS cycles. On cycle k, A_en is one-hot at bit k. A_in holds the registered vector on all rows for the whole of ISSUE.
- DRAIN: count so that P_out_last is captured exactly (ROWS-1)+MAC_LAT cycles after the first ISSUE cycle; this equals 1 cycle after the last A_en when MAC_LAT=1. Then go to OUT.
- OUT: res_valid=1. res_data stays stable until res_ready. After the handshake, go to READY.
- Arithmetic: the block does none. Data is passed and captured bit-exact, with no sign conversion.

## Timing
- Reset values: every output is 0 (wt_ready, act_ready, res_valid, W_en, A_en, W_in, A_in, P_in, res_data). The FSM is in IDLE and weights are treated as not loaded.
- A reset asserted mid-WLOAD, ISSUE or DRAIN aborts immediately. Any captured result is lost, and a fresh weight load is required.
- All outputs are registered; there is no combinational input-to-output path.
- W_en rises the cycle after the weight handshake.
- A_en[0] rises the cycle after the activation handshake.
- Throughput: one vector per ROWS + MAC_LAT + 2 cycles when res_ready is tied high. Vectors are not overlapped.
- In all states other than ISSUE, A_en=0. W_en is 0 outside WLOAD.
- When res_valid=1 and res_ready=0, the block holds indefinitely. act_ready stays 0.

## Structure
- Shared package mac_pkg holds:
  - the width constants (A/W/P_BITWIDTH);
  - sign-magnitude typedefs act_t, wgt_t and psum_t;
  - the feeder state enum.
- The block is a single module. The skew/drain counter is a local log2(ROWS+MAC_LAT+1)-bit counter, and no sub-module is needed.
- The bench instantiates ROWS mac instances chained as the column. Chaining follows the existing pattern: W_en for row r+1 is (W_en & W_ready[r]), and P flows from row to row.

## Test plan
- Reset: hold rst for 5 cycles, then release. Check that every output is 0, wt_ready=1 after one cycle, and act_ready=0.
- Weight load: wt_data = {0xF8, 0xB2, 0x3C} (rows 2, 1, 0).
  - Check W_en is high for 3 cycles with W_in = 0xF8, 0xB2, 0x3C in that order.
  - Check the column holds +60/-50/-120 and act_ready rises after W_ready_last.
- Compute with the weights above: act rows 0..2 = 0x0DB9, 0x07E3, 0x07E7.
  - Check A_en = 001, 010, 100 on consecutive cycles.
  - Check res_data = {1'b1, 39'd132930} (-132930).
- Backpressure: hold res_ready=0 for 10 cycles. Check res_data is stable, act_ready=0, and the result transfers on the cycle res_ready rises.
- Simultaneous wt_valid and act_valid in READY: the activation is accepted and wt_ready=0 that cycle. After the result, the reload proceeds with W_en high for 3 cycles.
- Reset mid-ISSUE: assert rst on the second A_en cycle. Check all outputs are 0 and the FSM is in IDLE (wt_ready=1, act_ready=0).

Source files
------------

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// mac_pkg: widths, sign-magnitude data types and feeder state encoding
// shared by the MAC column and its host-side feeder.
// Revision: 1.0
// ============================================================================
package mac_pkg;

  localparam int A_BITWIDTH = 16;
  localparam int W_BITWIDTH = 8;
  localparam int P_BITWIDTH = 40;

  typedef struct packed {
    logic                  sign;
    logic [A_BITWIDTH-2:0] mag;
  } act_t;

  typedef struct packed {
    logic                  sign;
    logic [W_BITWIDTH-2:0] mag;
  } wgt_t;

  typedef struct packed {
    logic                  sign;
    logic [P_BITWIDTH-2:0] mag;
  } psum_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WLOAD = 3'd1,
    ST_WWAIT = 3'd2,
    ST_READY = 3'd3,
    ST_ISSUE = 3'd4,
    ST_DRAIN = 3'd5,
    ST_OUT   = 3'd6
  } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/mac.sv
`default_nettype none
// ============================================================================
// mac: one sign-magnitude multiply-accumulate cell of the systolic column.
// Weight shifts through W_in/W_out; P_out = P_in + A_in*weight on A_en.
// Revision: 1.0
// ============================================================================
module mac
  import mac_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  W_en,
  input  wgt_t  W_in,
  output wgt_t  W_out,
  output logic  W_ready,
  input  logic  A_en,
  input  act_t  A_in,
  input  psum_t P_in,
  output psum_t P_out
);

  wgt_t  w_q;
  logic  w_ready_q;
  psum_t p_q;

  logic [P_BITWIDTH-2:0] prod_mag;
  logic                  prod_sign;
  psum_t                 sum_d;

  always_comb begin
    prod_mag  = (P_BITWIDTH-1)'(A_in.mag) * (P_BITWIDTH-1)'(w_q.mag);
    prod_sign = A_in.sign ^ w_q.sign;
    sum_d     = '0;
    if (prod_sign == P_in.sign) begin
      sum_d.sign = P_in.sign;
      sum_d.mag  = P_in.mag + prod_mag;
    end else if (P_in.mag >= prod_mag) begin
      sum_d.sign = P_in.sign;
      sum_d.mag  = P_in.mag - prod_mag;
    end else begin
      sum_d.sign = prod_sign;
      sum_d.mag  = prod_mag - P_in.mag;
    end
    // A zero sum is always reported as +0.
    if (sum_d.mag == '0) begin
      sum_d.sign = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q       <= '0;
      w_ready_q <= 1'b0;
      p_q       <= '0;
    end else begin
      if (W_en) begin
        w_q       <= W_in;
        w_ready_q <= 1'b1;
      end
      if (A_en) begin
        p_q <= sum_d;
      end
    end
  end

  assign W_out   = w_q;
  assign W_ready = w_ready_q;
  assign P_out   = p_q;

endmodule
`default_nettype wire

// File: rtl/mac_col_feeder.sv
`default_nettype none
// ============================================================================
// mac_col_feeder: loads one MAC column's weights, issues skewed activations
// row-by-row and returns the column's partial sum over a valid/ready port.
// Revision: 1.0
// ============================================================================
module mac_col_feeder
  import mac_pkg::*;
#(
  parameter int ROWS    = 3,
  parameter int MAC_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wt_valid,
  output logic                       wt_ready,
  input  logic [ROWS*W_BITWIDTH-1:0] wt_data,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [ROWS*A_BITWIDTH-1:0] act_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [P_BITWIDTH-1:0]      res_data,
  output logic                       W_en,
  output logic [W_BITWIDTH-1:0]      W_in,
  input  logic                       W_ready_last,
  output logic [ROWS-1:0]            A_en,
  output logic [ROWS*A_BITWIDTH-1:0] A_in,
  output logic [P_BITWIDTH-1:0]      P_in,
  input  logic [P_BITWIDTH-1:0]      P_out_last
);

  localparam int CNT_W = $clog2(ROWS + MAC_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ROWS  = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(ROWS + MAC_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam int WTOP = ROWS * W_BITWIDTH;

  feeder_state_e               state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [ROWS*W_BITWIDTH-1:0]  wbuf_q;
  logic                        wt_ready_q;
  logic                        act_ready_q;
  logic                        res_valid_q;
  logic [P_BITWIDTH-1:0]       res_data_q;
  logic                        w_en_q;
  logic [W_BITWIDTH-1:0]       w_in_q;
  logic [ROWS-1:0]             a_en_q;
  logic [ROWS*A_BITWIDTH-1:0]  a_in_q;

  logic wt_hs;
  logic act_hs;
  logic res_hs;

  assign wt_hs  = wt_valid & wt_ready_q;
  assign act_hs = act_valid & act_ready_q;
  assign res_hs = res_valid_q & res_ready;

  // Weights are shifted out from the top slice, so the deepest row goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wbuf_q      <= '0;
      wt_ready_q  <= 1'b0;
      act_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      w_en_q      <= 1'b0;
      w_in_q      <= '0;
      a_en_q      <= '0;
      a_in_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          wt_ready_q <= 1'b1;
          if (wt_hs) begin
            wt_ready_q <= 1'b0;
            w_en_q     <= 1'b1;
            w_in_q     <= wt_data[WTOP-1 -: W_BITWIDTH];
            wbuf_q     <= wt_data << W_BITWIDTH;
            cnt_q      <= CNT_ONE;
            state_q    <= ST_WLOAD;
          end
        end
        ST_WLOAD: begin
          if (cnt_q == CNT_ROWS) begin
            w_en_q  <= 1'b0;
            w_in_q  <= '0;
            state_q <= ST_WWAIT;
          end else begin
            w_in_q <= wbuf_q[WTOP-1 -: W_BITWIDTH];
            wbuf_q <= wbuf_q << W_BITWIDTH;
            cnt_q  <= cnt_q + CNT_ONE;
          end
        end
        ST_WWAIT: begin
          if (W_ready_last) begin
            wt_ready_q  <= 1'b1;
            act_ready_q <= 1'b1;
            state_q     <= ST_READY;
          end
        end
        ST_READY: begin
          // An activation beats a concurrent weight; the weight stays pending.
          if (act_hs) begin
            wt_ready_q  <= 1'b0;
            act_ready_q <= 1'b0;
            a_in_q      <= act_data;
            a_en_q      <= ROWS'(1);
            cnt_q       <= CNT_ONE;
            state_q     <= ST_ISSUE;
          end else if (wt_hs) begin
            wt_ready_q  <= 1'b0;
            act_ready_q <= 1'b0;
            w_en_q      <= 1'b1;
            w_in_q      <= wt_data[WTOP-1 -: W_BITWIDTH];
            wbuf_q      <= wt_data << W_BITWIDTH;
            cnt_q       <= CNT_ONE;
            state_q     <= ST_WLOAD;
          end
        end
        ST_ISSUE: begin
          if (cnt_q == CNT_ROWS) begin
            a_en_q  <= '0;
            a_in_q  <= '0;
            cnt_q   <= cnt_q + CNT_ONE;
            state_q <= ST_DRAIN;
          end else begin
            a_en_q <= a_en_q << 1;
            cnt_q  <= cnt_q + CNT_ONE;
          end
        end
        ST_DRAIN: begin
          // The bottom row's sum settles MAC_LAT cycles after its A_en.
          if (cnt_q == CNT_DRAIN) begin
            res_data_q  <= P_out_last;
            res_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_OUT: begin
          if (res_hs) begin
            res_valid_q <= 1'b0;
            wt_ready_q  <= 1'b1;
            act_ready_q <= 1'b1;
            state_q     <= ST_READY;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wt_ready  = wt_ready_q;
  assign act_ready = act_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign W_en      = w_en_q;
  assign W_in      = w_in_q;
  assign A_en      = a_en_q;
  assign A_in      = a_in_q;
  assign P_in      = '0;

endmodule
`default_nettype wire

// File: tb/tb_mac_col_feeder.sv
`default_nettype none
// ============================================================================
// tb_mac_col_feeder: feeder driving a 3-row MAC column, checked against an
// arithmetic sign-magnitude dot-product model.
// Revision: 1.0
// ============================================================================
module tb_mac_col_feeder;
  import mac_pkg::*;

  localparam int ROWS = 3;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       wt_valid;
  logic                       wt_ready;
  logic [ROWS*W_BITWIDTH-1:0] wt_data;
  logic                       act_valid;
  logic                       act_ready;
  logic [ROWS*A_BITWIDTH-1:0] act_data;
  logic                       res_valid;
  logic                       res_ready;
  logic [P_BITWIDTH-1:0]      res_data;
  logic                       W_en;
  logic [W_BITWIDTH-1:0]      W_in;
  logic                       W_ready_last;
  logic [ROWS-1:0]            A_en;
  logic [ROWS*A_BITWIDTH-1:0] A_in;
  logic [P_BITWIDTH-1:0]      P_in;
  logic [P_BITWIDTH-1:0]      P_out_last;

  int checks = 0;
  int errors = 0;
  logic [ROWS*W_BITWIDTH-1:0] model_w;
  logic [P_BITWIDTH-1:0]      last_res;

  always #5 clk = ~clk;

  mac_col_feeder #(.ROWS(ROWS), .MAC_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .W_en(W_en), .W_in(W_in), .W_ready_last(W_ready_last),
    .A_en(A_en), .A_in(A_in), .P_in(P_in), .P_out_last(P_out_last)
  );

  logic  w_en_c [ROWS];
  wgt_t  w_c    [ROWS+1];
  psum_t p_c    [ROWS+1];
  logic  w_rdy  [ROWS];

  assign w_c[0] = wgt_t'(W_in);
  assign p_c[0] = psum_t'(P_in);

  for (genvar r = 0; r < ROWS; r++) begin : g_col
    if (r == 0) begin : g_head
      assign w_en_c[r] = W_en;
    end else begin : g_tail
      assign w_en_c[r] = w_en_c[r-1] & w_rdy[r-1];
    end
    mac u_mac (
      .clk(clk), .rst(rst),
      .W_en(w_en_c[r]), .W_in(w_c[r]), .W_out(w_c[r+1]), .W_ready(w_rdy[r]),
      .A_en(A_en[r]), .A_in(act_t'(A_in[r*A_BITWIDTH +: A_BITWIDTH])),
      .P_in(p_c[r]), .P_out(p_c[r+1])
    );
  end

  assign W_ready_last = w_rdy[ROWS-1];
  assign P_out_last   = p_c[ROWS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sm_val(input logic [63:0] v, input int bits);
    longint mag;
    mag = longint'(v & ((64'd1 << (bits - 1)) - 64'd1));
    return v[bits-1] ? -mag : mag;
  endfunction

  // Expected column sum: plain signed dot product, re-encoded as sign-magnitude.
  function automatic logic [P_BITWIDTH-1:0] model_res(input logic [ROWS*A_BITWIDTH-1:0] a);
    longint acc = 0;
    logic [P_BITWIDTH-1:0] r;
    for (int i = 0; i < ROWS; i++)
      acc += sm_val(64'(model_w[i*W_BITWIDTH +: W_BITWIDTH]), W_BITWIDTH) *
             sm_val(64'(a[i*A_BITWIDTH +: A_BITWIDTH]), A_BITWIDTH);
    r = '0;
    r[P_BITWIDTH-2:0] = (P_BITWIDTH-1)'(acc < 0 ? -acc : acc);
    r[P_BITWIDTH-1]   = (acc < 0);
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_wt_ready"},  64'(wt_ready),  64'd0);
    chk({tag, "_act_ready"}, 64'(act_ready), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_W_en"},      64'(W_en),      64'd0);
    chk({tag, "_A_en"},      64'(A_en),      64'd0);
    chk({tag, "_W_in"},      64'(W_in),      64'd0);
    chk({tag, "_A_in"},      64'(A_in),      64'd0);
    chk({tag, "_P_in"},      64'(P_in),      64'd0);
    chk({tag, "_res_data"},  64'(res_data),  64'd0);
  endtask

  // All tasks start at a negedge; handshakes complete on the following posedge.
  task automatic send_wt(input logic [ROWS*W_BITWIDTH-1:0] d);
    int n = 0;
    wt_valid = 1'b1;
    wt_data  = d;
    while (!wt_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("wt_ready_timeout", 64'(wt_ready), 64'd1);
    @(posedge clk); #1;
    wt_valid = 1'b0;
  endtask

  task automatic load_weights(input logic [ROWS*W_BITWIDTH-1:0] d);
    int n = 0;
    send_wt(d);
    model_w = d;
    for (int k = 0; k < ROWS; k++) begin
      @(negedge clk);
      chk("wload_W_en", 64'(W_en), 64'd1);
      chk("wload_W_in", 64'(W_in), 64'(d[(ROWS-1-k)*W_BITWIDTH +: W_BITWIDTH]));
    end
    @(negedge clk);
    chk("wload_W_en_off", 64'(W_en), 64'd0);
    while (!act_ready && n < 50) begin @(negedge clk); n++; end
    chk("wload_act_ready", 64'(act_ready), 64'd1);
    chk("wload_W_ready_last", 64'(W_ready_last), 64'd1);
    for (int r = 0; r < ROWS; r++)
      chk("column_weight", 64'(w_c[r+1]), 64'(d[r*W_BITWIDTH +: W_BITWIDTH]));
  endtask

  task automatic send_act(input logic [ROWS*A_BITWIDTH-1:0] a);
    int n = 0;
    act_valid = 1'b1;
    act_data  = a;
    while (!act_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("act_ready_timeout", 64'(act_ready), 64'd1);
    @(posedge clk); #1;
    act_valid = 1'b0;
  endtask

  task automatic expect_issue(input logic [ROWS*A_BITWIDTH-1:0] a);
    for (int k = 0; k < ROWS; k++) begin
      @(negedge clk);
      chk("issue_A_en", 64'(A_en), 64'(1) << k);
      chk("issue_A_in", 64'(A_in), 64'(a));
      chk("issue_W_en", 64'(W_en), 64'd0);
    end
    @(negedge clk);
    chk("drain_A_en", 64'(A_en), 64'd0);
  endtask

  task automatic expect_result(input logic [ROWS*A_BITWIDTH-1:0] a, input int hold);
    logic [P_BITWIDTH-1:0] exp;
    int n = 0;
    exp = model_res(a);
    res_ready = (hold == 0);
    @(negedge clk);
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("res_valid", 64'(res_valid), 64'd1);
    chk("res_data", 64'(res_data), 64'(exp));
    last_res = res_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_res_data", 64'(res_data), 64'(exp));
      chk("hold_act_ready", 64'(act_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_res_valid", 64'(res_valid), 64'd0);
    chk("post_act_ready", 64'(act_ready), 64'd1);
  endtask

  task automatic run_vector(input logic [ROWS*A_BITWIDTH-1:0] a, input int hold);
    send_act(a);
    expect_issue(a);
    expect_result(a, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROWS*A_BITWIDTH-1:0] a;
    logic [ROWS*W_BITWIDTH-1:0] w2;
    rst = 1'b1; wt_valid = 1'b0; wt_data = '0;
    act_valid = 1'b0; act_data = '0; res_ready = 1'b1;
    model_w = '0; last_res = '0;

    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_wt_ready", 64'(wt_ready), 64'd1);
    chk("idle_act_ready", 64'(act_ready), 64'd0);

    load_weights({8'hF8, 8'hB2, 8'h3C});
    a = {16'h07E7, 16'h07E3, 16'h0DB9};
    run_vector(a, 10);
    chk("directed_res", 64'(last_res), 64'({1'b1, 39'd132930}));

    // Concurrent weight and activation: activation first, weight stays pending.
    w2 = {8'h05, 8'h8A, 8'h7F};
    a  = {16'h8123, 16'h0456, 16'h7FFF};
    wt_valid = 1'b1; wt_data = w2;
    act_valid = 1'b1; act_data = a;
    @(posedge clk); #1;
    act_valid = 1'b0;
    @(negedge clk);
    chk("both_wt_ready", 64'(wt_ready), 64'd0);
    chk("both_A_en", 64'(A_en), 64'd1);
    for (int k = 1; k < ROWS; k++) @(negedge clk);
    @(negedge clk);
    expect_result(a, 0);
    load_weights(w2);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) load_weights(ROWS*W_BITWIDTH'($urandom));
      a = {16'($urandom), 16'($urandom), 16'($urandom)};
      run_vector(a, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of ISSUE.
    a = {16'h1111, 16'h2222, 16'h3333};
    send_act(a);
    @(negedge clk);
    chk("mid_A_en0", 64'(A_en), 64'd1);
    @(negedge clk);
    chk("mid_A_en1", 64'(A_en), 64'd2);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_wt_ready", 64'(wt_ready), 64'd1);
    chk("midrst_act_ready", 64'(act_ready), 64'd0);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);

    load_weights({8'h81, 8'h40, 8'hC0});
    run_vector({16'h8001, 16'h0100, 16'h0200}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
